// File: rtl/mem_port_arbiter_if.sv
// One requester port of the memory arbiter: valid/ready request plus registered read response.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between fetch (req0) and load/store (req1).
// Ready is combinational in the grant cycle; read data returns one cycle later, during which no grant is made.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  mem_port_arbiter_if.slave     req0,
  mem_port_arbiter_if.slave     req1,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

  logic                  grant;
  logic                  winner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    winner = req1.valid;
    if (req0.valid && req1.valid) winner = ~last_grant;
    grant     = rstn && (state == IDLE) && (req0.valid || req1.valid);
    sel_we    = winner ? req1.we    : req0.we;
    sel_addr  = winner ? req1.addr  : req0.addr;
    sel_wdata = winner ? req1.wdata : req0.wdata;
  end

  assign req0.ready  = grant & ~winner;
  assign req1.ready  = grant &  winner;
  assign req0.rvalid = rvalid0_q & rstn;
  assign req1.rvalid = rvalid1_q & rstn;
  assign req0.rdata  = mem_data_out;
  assign req1.rdata  = mem_data_out;

  assign mem_wr_en      = grant &  sel_we;
  assign mem_rd_en      = grant & ~sel_we;
  assign mem_wr_address = rstn ? sel_addr  : '0;
  assign mem_rd_address = rstn ? sel_addr  : '0;
  assign mem_data_in    = rstn ? sel_wdata : '0;

  // The rvalid flops double as the registered owner id of the outstanding read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= winner;
            if (!sel_we) begin
              state     <= RD_WAIT;
              rvalid0_q <= ~winner;
              rvalid1_q <=  winner;
            end
          end
        end
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read memory model.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_address, mem_rd_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem [32];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0 ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1 ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req0           (r0.slave),
    .req1           (r1.slave),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_address (mem_wr_address),
    .mem_data_in    (mem_data_in),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_address (mem_rd_address),
    .mem_data_out   (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_address] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_rd_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0.valid = v; r0.we = we; r0.addr = a; r0.wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1.valid = v; r1.we = we; r1.addr = a; r1.wdata = d;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] exp_data [4];
    logic [AW-1:0] rd_addrs [4];
    exp_data = '{32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'hB0B0B0B0};
    rd_addrs = '{5'd1, 5'd2, 5'd3, 5'd5};

    rstn = 1'b0;
    drive0(1'b1, 1'b1, 5'd7, 32'h12345678);
    drive1(1'b0, 1'b0, 5'd0, 32'h0);
    step; #1;
    check("rst_ready0", r0.ready, 1'b0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_wr_addr", mem_wr_address, 5'd0);
    check("rst_data_in", mem_data_in, 32'h0);
    check("rst_rvalid", {r0.rvalid, r1.rvalid}, 2'b00);

    // Test 1: write then read back.
    step; rstn = 1'b1;
    drive0(1'b1, 1'b1, 5'd3, 32'hDEADBEEF); #1;
    check("t1_wr_ready0", r0.ready, 1'b1);
    check("t1_wr_en", mem_wr_en, 1'b1);
    check("t1_wr_addr", mem_wr_address, 5'd3);
    check("t1_wr_data", mem_data_in, 32'hDEADBEEF);
    step;
    drive0(1'b0, 1'b0, 5'd0, 32'h0);
    drive1(1'b1, 1'b0, 5'd3, 32'h0); #1;
    check("t1_rd_ready1", r1.ready, 1'b1);
    check("t1_rd_en", mem_rd_en, 1'b1);
    check("t1_rd_addr", mem_rd_address, 5'd3);
    step;
    drive1(1'b0, 1'b0, 5'd0, 32'h0); #1;
    check("t1_rvalid", {r0.rvalid, r1.rvalid}, 2'b01);
    check("t1_rdata", r1.rdata, 32'hDEADBEEF);
    check("t1_wait_rd_en", mem_rd_en, 1'b0);

    // Preload addr 1 via req0 and addr 2 via req1 (leaves last grant = req1).
    step; drive0(1'b1, 1'b1, 5'd1, 32'h11111111); #1;
    check("pre_ready0", r0.ready, 1'b1);
    step; drive0(1'b0, 1'b0, 5'd0, 32'h0);
    drive1(1'b1, 1'b1, 5'd2, 32'h22222222); #1;
    check("pre_ready1", r1.ready, 1'b1);

    // Test 2: contending reads alternate 0,1,0,1.
    step;
    drive0(1'b1, 1'b0, 5'd1, 32'h0);
    drive1(1'b1, 1'b0, 5'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_ready", {r0.ready, r1.ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t2_rd_addr", mem_rd_address, (i % 2 == 0) ? 5'd1 : 5'd2);
      step; #1;
      check("t2_wait_ready", {r0.ready, r1.ready}, 2'b00);
      check("t2_rvalid", {r0.rvalid, r1.rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t2_rdata", r0.rdata, (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
      step;
    end

    // Test 3: contending writes alternate every cycle.
    drive0(1'b1, 1'b1, 5'd4, 32'hA0A0A0A0);
    drive1(1'b1, 1'b1, 5'd5, 32'hB0B0B0B0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_wr_en", mem_wr_en, 1'b1);
      check("t3_ready", {r0.ready, r1.ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t3_wr_addr", mem_wr_address, (i % 2 == 0) ? 5'd4 : 5'd5);
      step;
    end

    // Test 4: req1 arrives during req0's read wait.
    drive0(1'b1, 1'b0, 5'd4, 32'h0);
    drive1(1'b0, 1'b0, 5'd0, 32'h0); #1;
    check("t4_ready0", r0.ready, 1'b1);
    step;
    drive0(1'b0, 1'b0, 5'd0, 32'h0);
    drive1(1'b1, 1'b0, 5'd5, 32'h0); #1;
    check("t4_wait_ready1", r1.ready, 1'b0);
    check("t4_rvalid0", {r0.rvalid, r1.rvalid}, 2'b10);
    check("t4_rdata0", r0.rdata, 32'hA0A0A0A0);
    step; #1;
    check("t4_ready1", r1.ready, 1'b1);
    check("t4_rd_addr", mem_rd_address, 5'd5);
    step; drive1(1'b0, 1'b0, 5'd0, 32'h0); #1;
    check("t4_rvalid1", {r0.rvalid, r1.rvalid}, 2'b01);
    check("t4_rdata1", r1.rdata, 32'hB0B0B0B0);

    // Test 5: reset during the read wait (req0 last granted before reset).
    step; drive0(1'b1, 1'b0, 5'd4, 32'h0); #1;
    check("t5_ready0", r0.ready, 1'b1);
    step; rstn = 1'b0; drive0(1'b0, 1'b0, 5'd0, 32'h0); #1;
    check("t5_rst_rvalid", {r0.rvalid, r1.rvalid}, 2'b00);
    step; #1;
    check("t5_rst_rvalid2", {r0.rvalid, r1.rvalid}, 2'b00);
    step; rstn = 1'b1;
    drive0(1'b1, 1'b0, 5'd4, 32'h0);
    drive1(1'b1, 1'b0, 5'd5, 32'h0); #1;
    check("t5_tie_ready", {r0.ready, r1.ready}, 2'b10);
    check("t5_no_rvalid", {r0.rvalid, r1.rvalid}, 2'b00);
    step; drive0(1'b0, 1'b0, 5'd0, 32'h0);
    drive1(1'b0, 1'b0, 5'd0, 32'h0); #1;
    check("t5_rvalid0", {r0.rvalid, r1.rvalid}, 2'b10);
    check("t5_rdata0", r0.rdata, 32'hA0A0A0A0);

    // Test 6: req1 alone issues four back-to-back reads.
    step;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b0, rd_addrs[i], 32'h0); #1;
      check("t6_ready1", r1.ready, 1'b1);
      check("t6_rd_addr", mem_rd_address, rd_addrs[i]);
      step;
      if (i == 3) drive1(1'b0, 1'b0, 5'd0, 32'h0);
      else        drive1(1'b1, 1'b0, rd_addrs[i+1], 32'h0);
      #1;
      check("t6_wait_ready1", r1.ready, 1'b0);
      check("t6_rvalid", {r0.rvalid, r1.rvalid}, 2'b01);
      check("t6_rdata", r1.rdata, exp_data[i]);
      step;
    end
    #1;
    check("t6_idle_rvalid", {r0.rvalid, r1.rvalid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
